// File: rtl/uart_pkg.sv
// uart_pkg: state encodings, status-word layout and bit-timing constants
// shared by the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_HIGH = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } rx_state_t;

    localparam int VALID_BIT   = 8;
    localparam int OVERRUN_BIT = 9;
    localparam int FERR_BIT    = 10;

    localparam logic [3:0] MID_TICK  = 4'd7;
    localparam logic [3:0] LAST_TICK = 4'd15;

    function automatic logic [31:0] status_word(input logic [7:0] data,
                                                input logic       valid,
                                                input logic       overrun,
                                                input logic       ferr);
        logic [31:0] w;
        w              = 32'd0;
        w[7:0]         = data;
        w[VALID_BIT]   = valid;
        w[OVERRUN_BIT] = overrun;
        w[FERR_BIT]    = ferr;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous FIFO with wrap-bit pointers; a pop frees
// the slot a same-cycle push into a full FIFO then reuses.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; reset empties the queue
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; contents are only visible through the pointers
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver on the picorv32-style bus, sampling on a
// 16x baud reference and queueing bytes for the CPU to poll.
module uart_rx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic        baudClock,
    input  logic        serialIn,
    output logic        probe
);
    typedef logic [$clog2(OVERSAMPLE)-1:0] tick_t;

    logic       rx_meta_r, rx_s;
    logic       baud_meta_r, baud_sync_r, baud_prev_r, tick_s;
    rx_state_t  state_r, state_n;
    tick_t      tick_cnt_r, tick_cnt_n;
    logic [2:0] bit_cnt_r, bit_cnt_n;
    logic [7:0] shifter_r, shifter_n;
    logic       push_s, ferr_set_s, pop_s, clear_s, ovr_set_s;
    logic       full_s, empty_s;
    logic [7:0] head_s;
    logic       overrun_r, frame_err_r, rdy_r, probe_r;
    logic       unused_s;

    assign unused_s = ^{mem_instr, mem_wdata, mem_addr};
    assign tick_s   = baud_sync_r & ~baud_prev_r;

    // Synchronizers for the serial line and baud reference, plus baud edge history
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_r   <= 1'b1;
            rx_s        <= 1'b1;
            baud_meta_r <= 1'b0;
            baud_sync_r <= 1'b0;
            baud_prev_r <= 1'b0;
        end else begin
            rx_meta_r   <= serialIn;
            rx_s        <= rx_meta_r;
            baud_meta_r <= baudClock;
            baud_sync_r <= baud_meta_r;
            baud_prev_r <= baud_sync_r;
        end
    end

    // Receiver state register; probe is registered from the next state so it tracks state exactly
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            tick_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            shifter_r  <= 8'd0;
            probe_r    <= 1'b0;
        end else begin
            state_r    <= state_n;
            tick_cnt_r <= tick_cnt_n;
            bit_cnt_r  <= bit_cnt_n;
            shifter_r  <= shifter_n;
            probe_r    <= (state_n != IDLE);
        end
    end

    // Next-state logic; everything moves only on a baud tick
    always_comb begin
        state_n    = state_r;
        tick_cnt_n = tick_cnt_r;
        bit_cnt_n  = bit_cnt_r;
        shifter_n  = shifter_r;
        push_s     = 1'b0;
        ferr_set_s = 1'b0;
        if (tick_s) begin
            case (state_r)
                WAIT_HIGH: begin
                    if (rx_s) state_n = IDLE;
                    else      state_n = WAIT_HIGH;
                end
                IDLE: begin
                    if (!rx_s) begin
                        state_n    = START;
                        tick_cnt_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                START: begin
                    if (tick_cnt_r == tick_t'(MID_TICK)) begin
                        if (!rx_s) begin
                            state_n    = DATA;
                            tick_cnt_n = '0;
                            bit_cnt_n  = 3'd0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt_r + tick_t'(1'b1);
                    end
                end
                DATA: begin
                    if (tick_cnt_r == tick_t'(LAST_TICK)) begin
                        shifter_n  = {rx_s, shifter_r[7:1]};
                        tick_cnt_n = '0;
                        if (bit_cnt_r == 3'd7) state_n = STOP;
                        else                   bit_cnt_n = bit_cnt_r + 3'd1;
                    end else begin
                        tick_cnt_n = tick_cnt_r + tick_t'(1'b1);
                    end
                end
                STOP: begin
                    if (tick_cnt_r == tick_t'(LAST_TICK)) begin
                        tick_cnt_n = '0;
                        if (rx_s) begin
                            push_s  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ferr_set_s = 1'b1;
                            state_n    = WAIT_HIGH;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt_r + tick_t'(1'b1);
                    end
                end
                default: state_n = WAIT_HIGH;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk   (clk),
        .resetn(resetn),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (shifter_r),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

    assign pop_s     = rdy_r & (mem_wstrb == 4'd0);
    assign clear_s   = rdy_r & (mem_wstrb != 4'd0);
    assign ovr_set_s = push_s & full_s & ~pop_s;

    // Bus acknowledge and sticky error flags; a set beats a same-cycle clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_r       <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rdy_r <= mem_valid & enable & ~rdy_r;
            if (ovr_set_s)    overrun_r <= 1'b1;
            else if (clear_s) overrun_r <= 1'b0;
            else              overrun_r <= overrun_r;
            if (ferr_set_s)   frame_err_r <= 1'b1;
            else if (clear_s) frame_err_r <= 1'b0;
            else              frame_err_r <= frame_err_r;
        end
    end

    // Read data drives zero when deselected so several slaves can be OR-ed
    always_comb begin
        mem_rdata = 32'd0;
        if (enable) begin
            mem_rdata = status_word(empty_s ? 8'd0 : head_s, ~empty_s, overrun_r, frame_err_r);
        end else begin
            mem_rdata = 32'd0;
        end
    end

    assign mem_ready = rdy_r & enable;
    assign probe     = probe_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and scoreboard checks of uart_rx frame reception,
// FIFO/overrun behaviour, framing errors, glitch rejection and reset.
module tb_uart_rx;
    localparam int DEPTH = 4;

    typedef enum logic [1:0] {OP_SEND, OP_BAD, OP_READ, OP_WRITE} op_t;
    typedef struct packed {
        op_t         op;
        logic [7:0]  data;
        logic [31:0] exp;
    } vec_t;

    logic        clk       = 1'b0;
    logic        resetn    = 1'b0;
    logic        enable    = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [3:0]  mem_wstrb = 4'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_addr  = 32'd0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        baudClock = 1'b0;
    logic        serialIn  = 1'b1;
    logic        probe;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(16)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (enable),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_instr(mem_instr),
        .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .baudClock(baudClock),
        .serialIn (serialIn),
        .probe    (probe)
    );

    always #5 clk = ~clk;
    always #50 baudClock = ~baudClock;

    function automatic vec_t mk(input op_t op, input logic [7:0] d, input logic [31:0] e);
        vec_t v;
        v.op   = op;
        v.data = d;
        v.exp  = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge baudClock);
    endtask

    task automatic bus_access(input logic [3:0] wstrb, output logic [31:0] rd);
        bit seen;
        seen = 1'b0;
        rd   = 32'hDEAD_BEEF;
        @(negedge clk);
        enable    = 1'b1;
        mem_valid = 1'b1;
        mem_wstrb = wstrb;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                rd   = mem_rdata;
                seen = 1'b1;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL bus_ready: mem_ready missing after 8 cycles, required 1");
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
    endtask

    task automatic read_check(input string name, input logic [31:0] exp);
        logic [31:0] rd;
        bus_access(4'd0, rd);
        check(name, rd, exp);
    endtask

    task automatic write_clear();
        logic [31:0] rd;
        bus_access(4'hF, rd);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge baudClock);
        serialIn = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            serialIn = b[i];
            wait_ticks(16);
        end
        serialIn = stop_bit;
        wait_ticks(16);
        serialIn = 1'b1;
        wait_ticks(4);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [20];
        logic [31:0] sb_q [$];
        logic [31:0] exp_w;
        logic [7:0]  b;

        vecs = '{
            mk(OP_SEND,  8'h55, 32'h0),   mk(OP_READ, 8'h00, 32'h0000_0155),
            mk(OP_READ,  8'h00, 32'h0),   mk(OP_BAD,  8'hA3, 32'h0),
            mk(OP_READ,  8'h00, 32'h0000_0400), mk(OP_WRITE, 8'h00, 32'h0),
            mk(OP_READ,  8'h00, 32'h0),   mk(OP_SEND, 8'h11, 32'h0),
            mk(OP_SEND,  8'h22, 32'h0),   mk(OP_SEND, 8'h33, 32'h0),
            mk(OP_SEND,  8'h44, 32'h0),   mk(OP_SEND, 8'h55, 32'h0),
            mk(OP_READ,  8'h00, 32'h0000_0311), mk(OP_READ, 8'h00, 32'h0000_0322),
            mk(OP_READ,  8'h00, 32'h0000_0333), mk(OP_READ, 8'h00, 32'h0000_0344),
            mk(OP_READ,  8'h00, 32'h0000_0200), mk(OP_WRITE, 8'h00, 32'h0),
            mk(OP_READ,  8'h00, 32'h0),   mk(OP_READ, 8'h00, 32'h0)
        };

        // Reset state
        repeat (5) @(negedge clk);
        enable = 1'b1;
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_probe", {31'd0, probe}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        resetn = 1'b1;
        wait_ticks(4);
        @(negedge clk);
        check("idle_probe", {31'd0, probe}, 32'd0);

        // Table of frames, reads and writes
        for (int i = 0; i < 20; i++) begin
            case (vecs[i].op)
                OP_SEND: send_frame(vecs[i].data, 1'b1);
                OP_BAD:  send_frame(vecs[i].data, 1'b0);
                OP_READ: read_check($sformatf("vec%0d_read", i), vecs[i].exp);
                default: write_clear();
            endcase
        end

        // Short start pulse is rejected
        @(posedge baudClock);
        serialIn = 1'b0;
        wait_ticks(2);
        @(negedge clk);
        check("glitch_probe_hi", {31'd0, probe}, 32'd1);
        wait_ticks(2);
        serialIn = 1'b1;
        wait_ticks(12);
        @(negedge clk);
        check("glitch_probe_lo", {31'd0, probe}, 32'd0);
        read_check("glitch_read", 32'd0);

        // Break for 40 bit times, then a good frame
        @(posedge baudClock);
        serialIn = 1'b0;
        wait_ticks(640);
        serialIn = 1'b1;
        wait_ticks(16);
        read_check("break_read", 32'h0000_0400);
        send_frame(8'h7E, 1'b1);
        read_check("after_break_7e", 32'h0000_057E);
        read_check("after_break_empty", 32'h0000_0400);
        write_clear();
        read_check("after_break_clear", 32'd0);

        // Scoreboard: random bytes queued, then drained in order
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom_range(0, 255));
            sb_q.push_back(32'h0000_0100 | {24'd0, b});
            send_frame(b, 1'b1);
        end
        @(negedge clk);
        enable    = 1'b0;
        mem_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("desel_ready", {31'd0, mem_ready}, 32'd0);
        check("desel_rdata", mem_rdata, 32'd0);
        mem_valid = 1'b0;
        while (sb_q.size() > 0) begin
            exp_w = sb_q.pop_front();
            read_check("sb_read", exp_w);
        end
        read_check("sb_empty", 32'd0);

        // Reset during data bit 4 of 0xC3
        b = 8'hC3;
        @(posedge baudClock);
        serialIn = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            serialIn = b[i];
            if (i == 4) begin
                wait_ticks(8);
                resetn = 1'b0;
                wait_ticks(8);
            end else begin
                wait_ticks(16);
            end
        end
        serialIn = 1'b1;
        wait_ticks(20);
        @(negedge clk);
        resetn = 1'b1;
        wait_ticks(2);
        @(negedge clk);
        check("post_rst_probe", {31'd0, probe}, 32'd0);
        read_check("post_rst_empty", 32'd0);
        send_frame(8'h3C, 1'b1);
        read_check("post_rst_3c", 32'h0000_013C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
